// File: rtl/prng_pkg.sv
// Shared types and helpers for the PRNG sample/display path.
package prng_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE,
        HOLD
    } disp_state_t;

    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/prng_sync_fifo.sv
// Small synchronous byte FIFO: register array, wrapping pointers, explicit level.
module prng_sync_fifo
    import prng_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned LW    = lvl_w(DEPTH),
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic [LW-1:0]     level_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      level_d = level_q + 1'b1;
            else if (!push_i && pop_i) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;
    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);

endmodule

// File: rtl/prng_sample_fifo.sv
// Buffers strobed PRNG bytes and shows each on disp_data for HOLD_TICKS cycles.
// Optional build macro PRNG_DUP_FILTER_EN discards a byte equal to the last accepted one.
module prng_sample_fifo
    import prng_pkg::*;
#(
    parameter  int unsigned DEPTH      = 4,
    parameter  int unsigned HOLD_TICKS = 10_000_000,
    parameter  int unsigned CNT_W      = 24,
    localparam int unsigned LW         = lvl_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_stb,
    input  logic [BYTE_W-1:0] in_data,
    output logic [BYTE_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              disp_new,
    output logic [LW-1:0]     fifo_level,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TICKS - 1);

    disp_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [BYTE_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic              new_q,   new_d;
    logic              ovf_q,   ovf_d;
    logic              push, pop, cand, dup, full, empty;
    logic [BYTE_W-1:0] head;

    prng_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!ena),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (in_data),
        .rd_data_o (head),
        .level_o   (fifo_level),
        .full_o    (full),
        .empty_o   (empty)
    );

`ifdef PRNG_DUP_FILTER_EN
    // Separate valid bit so a first byte of 8'h00 is never mistaken for a repeat.
    logic [BYTE_W-1:0] last_q;
    logic              last_vld_q;
    assign dup = last_vld_q && (in_data == last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (!ena) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_q     <= in_data;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign cand = in_stb && !dup;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        new_d   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (!empty) pop = 1'b1;
                    else        state_d = IDLE;
                end
            end
        endcase
        if (pop) begin
            data_d  = head;
            valid_d = 1'b1;
            new_d   = 1'b1;
        end
        // A same-edge pop frees the slot, so a push into a full FIFO still lands.
        push  = cand && (!full || pop);
        ovf_d = ovf_q || (cand && full && !pop);
        if (!ena) begin
            state_d = IDLE;
            cnt_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
            new_d   = 1'b0;
            ovf_d   = 1'b0;
            pop     = 1'b0;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            new_q   <= new_d;
            ovf_q   <= ovf_d;
        end
    end

    assign disp_data  = data_q;
    assign disp_valid = valid_q;
    assign disp_new   = new_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_prng_sample_fifo.sv
// Scoreboard bench for prng_sample_fifo; honours PRNG_DUP_FILTER_EN like the design.
module tb_prng_sample_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int          HOLD  = 5;
`ifdef PRNG_DUP_FILTER_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       in_stb = 1'b0;
    logic [7:0] in_data = '0;
    logic [7:0] disp_data;
    logic       disp_valid, disp_new, overflow;
    logic [2:0] fifo_level;

    prng_sample_fifo #(.DEPTH(DEPTH), .HOLD_TICKS(HOLD), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_stb     (in_stb),
        .in_data    (in_data),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_new   (disp_new),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         c;
    } ent_t;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: queue of stored bytes, display busy until edge next_free.
    logic [7:0] mq[$];
    ent_t       exp_q[$];
    ent_t       obs_q[$];
    int         cyc = 0;
    int         next_free = 0;
    logic [7:0] m_shown = '0;
    bit         m_valid = 0;
    bit         m_ovf = 0;
    bit         m_lv = 0;
    logic [7:0] m_last = '0;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        next_free = 0;
        m_shown   = '0;
        m_valid   = 0;
        m_ovf     = 0;
        m_lv      = 0;
        m_last    = '0;
    endtask

    task automatic model_step();
        bit ld, cand, room;
        if (!rst_n) begin
            model_clear();
            return;
        end
        cyc++;
        if (!ena) begin
            model_clear();
            return;
        end
        ld   = (mq.size() > 0) && (cyc >= next_free);
        cand = in_stb && !(DUP_EN && m_lv && in_data == m_last);
        room = (mq.size() < DEPTH) || ld;
        if (ld) begin
            m_shown = mq.pop_front();
            m_valid = 1;
            exp_q.push_back('{m_shown, cyc});
            next_free = cyc + HOLD;
        end
        if (cand) begin
            if (room) begin
                mq.push_back(in_data);
                m_last = in_data;
                m_lv   = 1;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Monitor: pops the scoreboard on each disp_new and checks steady-state outputs.
    initial forever begin
        ent_t e;
        @(negedge clk);
        if (disp_new) begin
            obs_q.push_back('{disp_data, cyc});
            if (exp_q.size() == 0) begin
                chk("unexpected_disp_new", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("load_data", int'(disp_data), int'(e.d));
                chk("load_cycle", cyc, e.c);
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("missed_load", 0, 1);
        end
        chk("disp_data", int'(disp_data), int'(m_shown));
        chk("disp_valid", int'(disp_valid), int'(m_valid));
        chk("fifo_level", int'(fifo_level), mq.size());
        chk("overflow", int'(overflow), int'(m_ovf));
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic drive(input bit s, input logic [7:0] d);
        @(negedge clk);
        in_stb  = s;
        in_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 8'h00);
    endtask

    task automatic ena_clear();
        @(negedge clk);
        in_stb = 0;
        ena    = 0;
        @(negedge clk);
        ena = 1;
    endtask

    initial begin
        int   sc;
        logic [7:0] t3[3];
        logic [7:0] t6in[5];
        logic [7:0] t6exp[$];

        repeat (2) @(negedge clk);
        chk("reset_disp_data", int'(disp_data), 0);
        chk("reset_level", int'(fifo_level), 0);
        rst_n = 1;
        idle(2);

        // single byte latency and hold
        obs_q.delete();
        drive(1, 8'hA5);
        drive(0, 8'h00);
        sc = cyc;
        idle(12);
        chk("t2_count", obs_q.size(), 1);
        if (obs_q.size() >= 1) begin
            chk("t2_data", int'(obs_q[0].d), 'hA5);
            chk("t2_latency", obs_q[0].c - sc, 1);
        end
        chk("t2_keep", int'(disp_data), 'hA5);
        chk("t2_valid", int'(disp_valid), 1);

        // back-to-back stream, loads spaced by HOLD
        t3 = '{8'h11, 8'h22, 8'h33};
        obs_q.delete();
        drive(1, t3[0]);
        drive(1, t3[1]);
        sc = cyc;
        drive(1, t3[2]);
        idle(20);
        chk("t3_count", obs_q.size(), 3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            chk("t3_data", int'(obs_q[i].d), int'(t3[i]));
            chk("t3_cycle", obs_q[i].c - sc, 1 + HOLD * i);
        end

        // overflow: 1 loaded, 4 queued, 6th dropped
        for (int i = 1; i <= 6; i++) drive(1, 8'(i));
        drive(0, 8'h00);
        chk("t4_level", int'(fifo_level), 4);
        chk("t4_overflow", int'(overflow), 1);
        ena_clear();
        chk("t4_clr_overflow", int'(overflow), 0);
        chk("t4_clr_level", int'(fifo_level), 0);
        chk("t4_clr_valid", int'(disp_valid), 0);
        chk("t4_clr_data", int'(disp_data), 0);

        // strobe into a full FIFO on the edge the hold expires
        for (int i = 0; i < 5; i++) drive(1, 8'h40 + 8'(i));
        drive(0, 8'h00);
        drive(1, 8'h50);
        drive(0, 8'h00);
        chk("t5_level", int'(fifo_level), 4);
        chk("t5_overflow", int'(overflow), 0);
        ena_clear();

        // asynchronous reset mid-hold
        for (int i = 0; i < 4; i++) drive(1, 8'h60 + 8'(i));
        drive(0, 8'h00);
        chk("t1_pre_level", int'(fifo_level), 3);
        #1 rst_n = 0;
        #1;
        chk("t1_async_data", int'(disp_data), 0);
        chk("t1_async_valid", int'(disp_valid), 0);
        chk("t1_async_new", int'(disp_new), 0);
        chk("t1_async_level", int'(fifo_level), 0);
        chk("t1_async_ovf", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1;
        idle(2);
        chk("t1_post_level", int'(fifo_level), 0);

        // duplicate filter
        t6in = '{8'h00, 8'h00, 8'h7E, 8'h7E, 8'h00};
        if (DUP_EN) t6exp = '{8'h00, 8'h7E, 8'h00};
        else        t6exp = '{8'h00, 8'h00, 8'h7E, 8'h7E, 8'h00};
        obs_q.delete();
        for (int i = 0; i < 5; i++) drive(1, t6in[i]);
        idle(40);
        chk("t6_count", obs_q.size(), t6exp.size());
        for (int i = 0; i < t6exp.size() && i < obs_q.size(); i++)
            chk("t6_data", int'(obs_q[i].d), int'(t6exp[i]));

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ena     = ($urandom_range(0, 99) != 0);
            in_stb  = ($urandom_range(0, 2) == 0);
            in_data = 8'($urandom_range(0, 3));
        end
        @(negedge clk);
        ena    = 1;
        in_stb = 0;
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
